// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one sram-like memory port between the instruction-fetch master
//   (inst_*) and the data-access master (data_*). Only one transaction is in
//   flight at a time. The owner stays locked from its request until the slave
//   returns data_ok.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no transaction; the winner is issued combinationally this cycle
//   ADDR  | request issued for owner, waiting for mem_addr_ok
//   DATA  | address accepted, waiting for mem_data_ok
//
// Parameters
//   ROUND_ROBIN  0: data master wins a tie; 1: the master not served last wins
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   inst_req/wr/size/addr/wdata instruction master request fields
//   inst_rdata/addr_ok/data_ok  instruction master responses
//   data_req/wr/size/addr/wdata data master request fields
//   data_rdata/addr_ok/data_ok  data master responses
//   mem_req/wr/size/addr/wdata  shared slave port request fields
//   mem_rdata/addr_ok/data_ok   shared slave port responses
//   busy                        high while a transaction is in progress
module sram_like_arbiter #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   owner, owner_nx;           // 0 = inst, 1 = data
  logic   last_owner, last_owner_nx;
  logic   sel;                       // IDLE winner
  logic   src;                       // master currently steering mem_*
  logic   src_req;
  logic   accept;
  logic   done;

  always_comb begin
    sel = data_req;
    if (inst_req && data_req) begin
      if (ROUND_ROBIN != 0) sel = ~last_owner;
      else                  sel = 1'b1;
    end
  end

  // In IDLE the fresh winner drives the port (0-cycle issue); afterwards the
  // locked owner does, so a late requester can never be switched in.
  assign src     = (state == IDLE) ? sel : owner;
  assign src_req = src ? data_req : inst_req;

  assign mem_req   = ~rst & (state != DATA) & src_req;
  assign mem_wr    = src ? data_wr    : inst_wr;
  assign mem_size  = src ? data_size  : inst_size;
  assign mem_addr  = src ? data_addr  : inst_addr;
  assign mem_wdata = src ? data_wdata : inst_wdata;

  assign accept = mem_req & mem_addr_ok;
  assign done   = ~rst & (state == DATA) & mem_data_ok;

  assign inst_addr_ok = accept & ~src;
  assign data_addr_ok = accept &  src;
  assign inst_data_ok = done & ~owner;
  assign data_data_ok = done &  owner;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign busy         = ~rst & (state != IDLE);

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    case (state)
      IDLE: begin
        if (src_req) begin
          owner_nx = sel;
          state_nx = mem_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        // A master dropping req here leaves mem_req low and the FSM parked.
        if (accept) state_nx = DATA;
      end
      DATA: begin
        if (mem_data_ok) begin
          state_nx      = IDLE;
          last_owner_nx = owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter
//   Two arbiters (index 0: fixed priority, index 1: round robin) with separate
//   stimulus. Directed steps exercise the listed scenarios, then random masters
//   and a random slave run against a transaction-level reference model.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        inst_req     [2];
  logic        inst_wr      [2];
  logic [1:0]  inst_size    [2];
  logic [31:0] inst_addr    [2];
  logic [31:0] inst_wdata   [2];
  logic [31:0] inst_rdata   [2];
  logic        inst_addr_ok [2];
  logic        inst_data_ok [2];
  logic        data_req     [2];
  logic        data_wr      [2];
  logic [1:0]  data_size    [2];
  logic [31:0] data_addr    [2];
  logic [31:0] data_wdata   [2];
  logic [31:0] data_rdata   [2];
  logic        data_addr_ok [2];
  logic        data_data_ok [2];
  logic        mem_req      [2];
  logic        mem_wr       [2];
  logic [1:0]  mem_size     [2];
  logic [31:0] mem_addr     [2];
  logic [31:0] mem_wdata    [2];
  logic [31:0] mem_rdata    [2];
  logic        mem_addr_ok  [2];
  logic        mem_data_ok  [2];
  logic        busy         [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    sram_like_arbiter #(.ROUND_ROBIN(k)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req[k]),
      .inst_wr      (inst_wr[k]),
      .inst_size    (inst_size[k]),
      .inst_addr    (inst_addr[k]),
      .inst_wdata   (inst_wdata[k]),
      .inst_rdata   (inst_rdata[k]),
      .inst_addr_ok (inst_addr_ok[k]),
      .inst_data_ok (inst_data_ok[k]),
      .data_req     (data_req[k]),
      .data_wr      (data_wr[k]),
      .data_size    (data_size[k]),
      .data_addr    (data_addr[k]),
      .data_wdata   (data_wdata[k]),
      .data_rdata   (data_rdata[k]),
      .data_addr_ok (data_addr_ok[k]),
      .data_data_ok (data_data_ok[k]),
      .mem_req      (mem_req[k]),
      .mem_wr       (mem_wr[k]),
      .mem_size     (mem_size[k]),
      .mem_addr     (mem_addr[k]),
      .mem_wdata    (mem_wdata[k]),
      .mem_rdata    (mem_rdata[k]),
      .mem_addr_ok  (mem_addr_ok[k]),
      .mem_data_ok  (mem_data_ok[k]),
      .busy         (busy[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      inst_req[k] = 1'b0;  inst_wr[k] = 1'b0;  inst_size[k] = 2'b10;
      inst_addr[k] = '0;   inst_wdata[k] = '0;
      data_req[k] = 1'b0;  data_wr[k] = 1'b0;  data_size[k] = 2'b10;
      data_addr[k] = '0;   data_wdata[k] = '0;
      mem_addr_ok[k] = 1'b0; mem_data_ok[k] = 1'b0; mem_rdata[k] = '0;
    end
  endtask

  // Transaction-level reference: a master is either not engaged, engaged but
  // not yet accepted, or accepted and waiting for its response.
  bit m_active [2] = '{1'b0, 1'b0};
  bit m_acc    [2] = '{1'b0, 1'b0};
  bit m_own    [2] = '{1'b0, 1'b0};
  bit m_last   [2] = '{1'b1, 1'b1};
  bit e_mreq, e_iaok, e_daok, e_idok, e_ddok, e_busy, who, any_req;
  bit log_en = 1'b0;
  int grants[$];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_mreq = 0; e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0; e_busy = 0;
      any_req = inst_req[k] | data_req[k];
      who = 0;
      if (!rst) begin
        e_busy = m_active[k];
        if (!m_active[k]) begin
          if (inst_req[k] && data_req[k]) who = (k == 1) ? ~m_last[k] : 1'b1;
          else                            who = data_req[k];
          e_mreq = any_req;
        end else if (!m_acc[k]) begin
          who    = m_own[k];
          e_mreq = who ? data_req[k] : inst_req[k];
        end else begin
          who    = m_own[k];
          e_idok = mem_data_ok[k] & ~who;
          e_ddok = mem_data_ok[k] &  who;
        end
        e_iaok = e_mreq & mem_addr_ok[k] & ~who;
        e_daok = e_mreq & mem_addr_ok[k] &  who;
      end

      chk($sformatf("m%0d_mem_req", k),      mem_req[k],      e_mreq);
      chk($sformatf("m%0d_inst_addr_ok", k), inst_addr_ok[k], e_iaok);
      chk($sformatf("m%0d_data_addr_ok", k), data_addr_ok[k], e_daok);
      chk($sformatf("m%0d_inst_data_ok", k), inst_data_ok[k], e_idok);
      chk($sformatf("m%0d_data_data_ok", k), data_data_ok[k], e_ddok);
      chk($sformatf("m%0d_busy", k),         busy[k],         e_busy);
      if (e_mreq) begin
        chk($sformatf("m%0d_mem_addr", k),  mem_addr[k],  who ? data_addr[k]  : inst_addr[k]);
        chk($sformatf("m%0d_mem_wdata", k), mem_wdata[k], who ? data_wdata[k] : inst_wdata[k]);
        chk($sformatf("m%0d_mem_wr", k),    mem_wr[k],    who ? data_wr[k]    : inst_wr[k]);
        chk($sformatf("m%0d_mem_size", k),  mem_size[k],  who ? data_size[k]  : inst_size[k]);
      end
      if (e_idok) chk($sformatf("m%0d_inst_rdata", k), inst_rdata[k], mem_rdata[k]);
      if (e_ddok) chk($sformatf("m%0d_data_rdata", k), data_rdata[k], mem_rdata[k]);

      if (log_en && k == 1) begin
        if (inst_addr_ok[1]) grants.push_back(0);
        if (data_addr_ok[1]) grants.push_back(1);
      end

      if (rst) begin
        m_active[k] = 0; m_acc[k] = 0; m_own[k] = 0; m_last[k] = 1;
      end else if (!m_active[k]) begin
        if (any_req) begin
          m_active[k] = 1; m_own[k] = who; m_acc[k] = mem_addr_ok[k];
        end
      end else if (!m_acc[k]) begin
        if (e_mreq && mem_addr_ok[k]) m_acc[k] = 1;
      end else if (mem_data_ok[k]) begin
        m_active[k] = 0; m_acc[k] = 0; m_last[k] = m_own[k];
      end
    end
  end

  bit iacc [2];
  bit dacc [2];

  initial begin
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // lone inst read, addr_ok same cycle, data_ok next cycle
    inst_req[0] = 1; inst_addr[0] = 32'hBFC0_0000; mem_addr_ok[0] = 1;
    @(negedge clk);
    chk("t1_inst_addr_ok", inst_addr_ok[0], 1);
    chk("t1_mem_addr", mem_addr[0], 32'hBFC0_0000);
    chk("t1_busy_issue", busy[0], 0);
    step();
    inst_req[0] = 0; mem_addr_ok[0] = 0; mem_data_ok[0] = 1; mem_rdata[0] = 32'h2408_0001;
    @(negedge clk);
    chk("t1_inst_data_ok", inst_data_ok[0], 1);
    chk("t1_inst_rdata", inst_rdata[0], 32'h2408_0001);
    chk("t1_busy_data", busy[0], 1);
    step();
    mem_data_ok[0] = 0;
    @(negedge clk);
    chk("t1_busy_after", busy[0], 0);

    // tie under fixed priority: data first, inst waits until after data_ok
    step();
    inst_req[0] = 1; inst_addr[0] = 32'h0000_1110;
    data_req[0] = 1; data_addr[0] = 32'h0000_2220; mem_addr_ok[0] = 1;
    @(negedge clk);
    chk("t2_data_addr_ok", data_addr_ok[0], 1);
    chk("t2_inst_addr_ok_tie", inst_addr_ok[0], 0);
    chk("t2_mem_addr_data", mem_addr[0], 32'h0000_2220);
    step();
    data_req[0] = 0; mem_addr_ok[0] = 1; mem_data_ok[0] = 1;
    @(negedge clk);
    chk("t2_data_data_ok", data_data_ok[0], 1);
    chk("t2_inst_addr_ok_in_data", inst_addr_ok[0], 0);
    chk("t2_mem_req_in_data", mem_req[0], 0);
    step();
    mem_data_ok[0] = 0;
    @(negedge clk);
    chk("t2_inst_addr_ok_next", inst_addr_ok[0], 1);
    chk("t2_mem_addr_inst", mem_addr[0], 32'h0000_1110);
    step();
    inst_req[0] = 0; mem_addr_ok[0] = 0; mem_data_ok[0] = 1;
    @(negedge clk);
    chk("t2_inst_data_ok", inst_data_ok[0], 1);
    step();
    mem_data_ok[0] = 0;

    // slave stalls addr_ok 3 cycles; data master arrives during the stall
    inst_req[0] = 1; inst_addr[0] = 32'h1000_0040;
    @(negedge clk);
    chk("t4_mem_addr_c0", mem_addr[0], 32'h1000_0040);
    step();
    @(negedge clk);
    chk("t4_busy_c1", busy[0], 1);
    step();
    data_req[0] = 1; data_addr[0] = 32'h2000_0080;
    @(negedge clk);
    chk("t4_mem_addr_c2", mem_addr[0], 32'h1000_0040);
    step();
    mem_addr_ok[0] = 1;
    @(negedge clk);
    chk("t4_inst_addr_ok", inst_addr_ok[0], 1);
    chk("t4_data_addr_ok_locked", data_addr_ok[0], 0);
    chk("t4_mem_addr_c3", mem_addr[0], 32'h1000_0040);
    step();
    inst_req[0] = 0;
    @(negedge clk);
    chk("t4_data_addr_ok_data", data_addr_ok[0], 0);
    step();
    mem_data_ok[0] = 1;
    @(negedge clk);
    chk("t4_inst_data_ok", inst_data_ok[0], 1);
    chk("t4_data_data_ok_none", data_data_ok[0], 0);
    step();
    mem_data_ok[0] = 0;
    @(negedge clk);
    chk("t4_data_addr_ok", data_addr_ok[0], 1);
    chk("t4_mem_addr_data", mem_addr[0], 32'h2000_0080);
    step();
    data_req[0] = 0; mem_addr_ok[0] = 0; mem_data_ok[0] = 1;
    @(negedge clk);
    chk("t4_data_data_ok", data_data_ok[0], 1);
    step();
    mem_data_ok[0] = 0;

    // data write with one stall cycle
    data_req[0] = 1; data_wr[0] = 1; data_size[0] = 2'b10;
    data_wdata[0] = 32'hDEAD_BEEF; data_addr[0] = 32'h8000_1000;
    @(negedge clk);
    chk("t6_mem_wr", mem_wr[0], 1);
    chk("t6_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    chk("t6_mem_addr", mem_addr[0], 32'h8000_1000);
    chk("t6_mem_size", mem_size[0], 2'b10);
    step();
    mem_addr_ok[0] = 1;
    @(negedge clk);
    chk("t6_data_addr_ok", data_addr_ok[0], 1);
    step();
    data_req[0] = 0; data_wr[0] = 0; mem_addr_ok[0] = 0; mem_data_ok[0] = 1;
    @(negedge clk);
    chk("t6_data_data_ok", data_data_ok[0], 1);
    step();
    mem_data_ok[0] = 0;

    // reset in DATA; a late data_ok must be dropped
    inst_req[0] = 1; inst_addr[0] = 32'h0000_0100; mem_addr_ok[0] = 1;
    @(negedge clk);
    chk("t5_inst_addr_ok", inst_addr_ok[0], 1);
    step();
    inst_req[0] = 0; mem_addr_ok[0] = 0;
    @(negedge clk);
    chk("t5_busy_data", busy[0], 1);
    step();
    rst = 1;
    @(negedge clk);
    chk("t5_busy_rst", busy[0], 0);
    step();
    rst = 0; mem_data_ok[0] = 1;
    @(negedge clk);
    chk("t5_inst_data_ok", inst_data_ok[0], 0);
    chk("t5_data_data_ok", data_data_ok[0], 0);
    chk("t5_busy_after", busy[0], 0);
    step();
    mem_data_ok[0] = 0;

    // round robin: continuous requests from both masters alternate grants
    inst_req[1] = 1; inst_addr[1] = 32'h0000_0A00;
    data_req[1] = 1; data_addr[1] = 32'h0000_0B00;
    mem_addr_ok[1] = 1; mem_data_ok[1] = 1;
    log_en = 1;
    repeat (12) begin
      @(negedge clk);
      step();
    end
    log_en = 0;
    idle_all();
    chk("t3_grant_count", grants.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_grant_%0d", i), (i < grants.size()) ? grants[i] : 2, i % 2);
    repeat (2) step();

    // random masters and slave on both arbiters
    repeat (3000) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        iacc[k] = inst_req[k] & inst_addr_ok[k];
        dacc[k] = data_req[k] & data_addr_ok[k];
      end
      step();
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        if (!inst_req[k] || iacc[k]) begin
          inst_req[k]   = ($urandom_range(0, 2) != 0);
          inst_wr[k]    = $urandom_range(0, 1) == 1;
          inst_size[k]  = 2'($urandom_range(0, 3));
          inst_addr[k]  = $urandom;
          inst_wdata[k] = $urandom;
        end
        if (!data_req[k] || dacc[k]) begin
          data_req[k]   = ($urandom_range(0, 2) != 0);
          data_wr[k]    = $urandom_range(0, 1) == 1;
          data_size[k]  = 2'($urandom_range(0, 3));
          data_addr[k]  = $urandom;
          data_wdata[k] = $urandom;
        end
        mem_addr_ok[k] = $urandom_range(0, 1) == 1;
        mem_data_ok[k] = $urandom_range(0, 1) == 1;
        mem_rdata[k]   = $urandom;
      end
    end
    rst = 0;
    idle_all();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
